scmem_lsu: RTL and testbench
============================

Name: scmem_lsu

Overview:
- Load/store unit directly upstream of the single-cycle data memory: sits between the CPU datapath and the 32x32 data RAM (async read, write on posedge clk when we=1, word index addr[6:2]).
- Adds byte/halfword loads with sign/zero extension, byte/halfword stores via read-modify-write, misalignment and range checking, and a req/ready/done handshake so the core can stall.
- Little-endian byte lanes.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the downstream RAM; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- RANGE_CHECK, 1, when 1, addresses >= 4*MEM_WORDS raise err; when 0, the upper address bits are passed through unchecked.

Ports:
- clk, input, 1, sole clock, rising edge.
- clrn, input, 1, reset, asynchronous, active-low.
- req, input, 1, access request; sampled only when ready=1.
- wr, input, 1, 1=store, 0=load.
- size, input, 2, access size: 00=byte, 01=half, 10=word, 11=reserved.
- sext, input, 1, loads only: 1 sign-extends, 0 zero-extends.
- addr, input, 32, byte address.
- wdata, input, 32, store data, right-justified (byte in [7:0], half in [15:0]).
- ready, output, 1, unit idle and able to accept req.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, valid with done: access rejected.
- rdata, output, 32, load result; valid with done, held until the next done.
- mem_addr, output, 32, to RAM addr; word aligned ({addr[31:2],2'b00}).
- mem_din, output, 32, to RAM datain.
- mem_we, output, 1, to RAM we.
- mem_dout, input, 32, from RAM dataout (combinational read).

Behaviour:
- Reset values: state=IDLE, ready=1, done=0, err=0, rdata=0, mem_addr=0, mem_din=0, mem_we=0.
- Request capture: in IDLE with req=1, latch wr, size, sext, addr and wdata. ready=1 only in IDLE; req outside IDLE is ignored.
- Error check at capture: err=1 if any of:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - RANGE_CHECK=1 and addr >= 4*MEM_WORDS.
- States:
  - IDLE: on req with error -> RESP(err=1). Load -> LOAD. Word store -> WRITE. Byte/half store -> READ.
  - LOAD: mem_addr=latched word address; at the clock edge capture the extracted lane into rdata -> RESP.
  - READ: mem_addr driven; at the edge latch mem_dout as old_word -> WRITE.
  - WRITE: mem_we=1; mem_din=wdata for a word store, otherwise the merge of old_word with the new lane. The RAM writes at this edge -> RESP.
  - RESP: done=1 for one cycle with err valid -> IDLE.
- mem_we is asserted only in WRITE and decoded from the state register, so it is glitch-free. mem_we is never asserted on an err path.
- Latency from req edge to done: word load 2 cycles, word store 2, byte/half store 3, error 1. Throughput: the next req is accepted in the cycle after done.
- Lane extract: byte k = addr[1:0] selects bits [8k+7:8k]; half uses addr[1] to select [31:16] or [15:0]. Extend per sext to 32 bits.
- Lane merge: replace only the addressed lane; all other bits keep old_word.
- rdata updates only on successful loads. Stores and errors leave rdata unchanged.
- On an err response, rdata holds its previous value.
- Reset mid-operation forces IDLE and drops mem_we immediately.
  - If reset arrives before the WRITE edge, memory is untouched.
  - No done is produced for the aborted access.

Decomposition:
- Shared package scmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - state encoding IDLE, LOAD, READ, WRITE, RESP.
- Sub-module scmem_lane: combinational lane extract/extend plus lane merge, inputs {word, new, addr[1:0], size, sext}. It is shared by the load and store paths.

Test Plan:
- RAM preloaded with 0x50=0x000000A3, 0x54=0x00000027, 0x5C=0x00000115. lw 0x5C -> done 2 cycles after req, rdata=0x00000115, err=0, mem_we never high.
- sb addr 0x55 wdata 0x000000FF:
  - READ then WRITE, mem_we high for exactly 1 cycle with mem_din=0x0000FF27, done at cycle 3;
  - then lb 0x55 sext=1 -> rdata=0xFFFFFFFF;
  - then lbu 0x55 -> rdata=0x000000FF.
- sh 0x5E wdata 0x0000ABCD:
  - word 0x5C becomes 0xABCD0115;
  - lh 0x5E sext=1 -> 0xFFFFABCD;
  - lhu 0x5C -> 0x00000115.
- Error cases each give done+err=1 one cycle after req, mem_we stays 0, RAM unchanged, and rdata keeps its prior value:
  - lw 0x52 (misaligned);
  - sh 0x51 (misaligned);
  - size=11;
  - sw 0x80 with RANGE_CHECK=1 (out of range).
- clrn pulled low during READ of sb 0x50 wdata 0x11:
  - mem_we never asserts, and there is no done;
  - word 0x50 stays 0x000000A3;
  - ready=1 immediately after clrn rises.
- req held high continuously issuing lw 0x50 then lw 0x54: second access accepted in the cycle after the first done; rdata 0x000000A3 then 0x00000027, with no request dropped or duplicated.

Source files
------------

// File: rtl/scmem_pkg.sv
// Shared encodings for the scmem load/store unit: access sizes and controller states.
package scmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/scmem_lane.sv
// Little-endian lane logic: extract/extend a byte or half from a word, and merge a new lane into it.
// Purely combinational; shared by the load path (extract) and the store read-modify-write (merge).
module scmem_lane
  import scmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] din,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = din;
    case (size)
      SZ_BYTE: begin
        ext    = {{24{sext & b[7]}}, b};
        merged = word;
        merged[{lane, 3'b000} +: 8] = din[7:0];
      end
      SZ_HALF: begin
        ext    = {{16{sext & h[15]}}, h};
        merged = lane[1] ? {din[15:0], word[15:0]} : {word[31:16], din[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/scmem_lsu.sv
// Load/store unit in front of a 32-bit async-read RAM: sub-word loads/stores, alignment/range errors.
// Latency req->done: error 1, load 2, word store 2, sub-word store 3; ready only in IDLE, req ignored otherwise.
module scmem_lsu
  import scmem_pkg::*;
#(
  parameter int MEM_WORDS   = 32,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

  state_e      state_q, state_d;
  logic        wr_q, sext_q, err_q;
  size_e       size_q;
  logic [31:0] addr_q, wdata_q, old_q, rdata_q;
  logic        req_err;
  logic [31:0] lane_word, lane_ext, lane_merged;

  always_comb begin
    req_err = (size == SZ_RSVD)
           || (size == SZ_HALF && addr[0])
           || (size == SZ_WORD && addr[1:0] != 2'b00)
           || (RANGE_CHECK && addr >= ADDR_LIM);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_err)              state_d = RESP;
          else if (!wr)             state_d = LOAD;
          else if (size == SZ_WORD) state_d = WRITE;
          else                      state_d = READ;
        end
      end
      LOAD:    state_d = RESP;
      READ:    state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enable comes straight from the state register so it cannot glitch.
  always_comb begin
    ready   = (state_q == IDLE);
    done    = (state_q == RESP);
    err     = (state_q == RESP) && err_q;
    mem_we  = (state_q == WRITE);
    mem_din = 32'h0;
    if (state_q == WRITE) mem_din = (size_q == SZ_WORD) ? wdata_q : lane_merged;
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign rdata     = rdata_q;
  assign lane_word = (state_q == WRITE) ? old_q : mem_dout;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      old_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          wr_q    <= wr;
          sext_q  <= sext;
          err_q   <= req_err;
          size_q  <= size_e'(size);
          addr_q  <= addr;
          wdata_q <= wdata;
        end
        LOAD:    rdata_q <= lane_ext;
        READ:    old_q   <= mem_dout;
        default: ;
      endcase
    end
  end

  scmem_lane u_lane (
    .word   (lane_word),
    .din    (wdata_q),
    .lane   (addr_q[1:0]),
    .size   (size_q),
    .sext   (sext_q),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

endmodule

// File: tb/tb_scmem_lsu.sv
// Bench for scmem_lsu with a behavioural 32x32 RAM and a scoreboard of expected responses.
module tb_scmem_lsu;

  logic        clk;
  logic        clrn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] ram [0:31];
  logic        preload;

  typedef struct {
    logic        e;
    logic [31:0] rd;
    int          lat;
    int          nwe;
    logic [31:0] din;
    int          t0;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic        exp_e;
  logic [31:0] exp_rd;
  int          exp_lat;
  int          exp_nwe;
  logic [31:0] exp_din;

  int tests, fails;
  int ncyc, we_cnt, acc_cnt, last_done;
  logic gap_chk;

  scmem_lsu #(.MEM_WORDS(32), .RANGE_CHECK(1'b1)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'h0;
      ram[20] <= 32'h000000A3;
      ram[21] <= 32'h00000027;
      ram[23] <= 32'h00000115;
    end else if (mem_we) begin
      ram[mem_addr[6:2]] <= mem_din;
    end
  end

  assign mem_dout = ram[mem_addr[6:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic monitor();
    if (!clrn) begin
      sbq.delete();
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end else begin
      if (sbq.size() == 0) check("we_idle", 32'(mem_we), 32'd0);
      else if (mem_we) begin
        we_cnt++;
        check("mem_din", mem_din, sbq[0].din);
      end
      if (done) begin
        if (sbq.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          cur = sbq.pop_front();
          check("err", 32'(err), 32'(cur.e));
          check("rdata", rdata, cur.rd);
          check("latency", 32'(ncyc - cur.t0), 32'(cur.lat));
          check("we_cycles", 32'(we_cnt), 32'(cur.nwe));
          last_done = ncyc;
        end
      end
    end
  endtask

  // Inputs are driven just after a falling edge; a request seen with ready here is taken at the next rising edge.
  task automatic step();
    if (clrn && req && ready) begin
      if (gap_chk) check("b2b_gap", 32'(ncyc - last_done), 32'd1);
      sbq.push_back('{exp_e, exp_rd, exp_lat, exp_nwe, exp_din, ncyc});
      we_cnt = 0;
      acc_cnt++;
    end
    @(negedge clk);
    ncyc++;
    monitor();
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 20 && acc_cnt < target; i++) step();
    check("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
    check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic op(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] wd, input logic e, input logic [31:0] rd, input int lat,
                    input int nwe, input logic [31:0] din);
    int n;
    wr = w; size = sz; sext = sx; addr = a; wdata = wd;
    exp_e = e; exp_rd = rd; exp_lat = lat; exp_nwe = nwe; exp_din = din;
    n = acc_cnt;
    req = 1'b1;
    wait_acc(n + 1);
    req = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tests = 0; fails = 0; ncyc = 0; we_cnt = 0; acc_cnt = 0; last_done = 0;
    gap_chk = 1'b0; preload = 1'b1;
    clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h0; wdata = 32'h0;
    exp_e = 1'b0; exp_rd = 32'h0; exp_lat = 0; exp_nwe = 0; exp_din = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done0", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    preload = 1'b0;
    clrn = 1'b1;
    step();

    // w  sz     sx  addr       wdata        err  rdata        lat we  mem_din
    op(0, 2'b10, 0, 32'h5C, 32'h0, 0, 32'h00000115, 2, 0, 32'h0);

    // back-to-back loads with req held high
    wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h50;
    exp_e = 1'b0; exp_rd = 32'h000000A3; exp_lat = 2; exp_nwe = 0; exp_din = 32'h0;
    n = acc_cnt;
    req = 1'b1;
    wait_acc(n + 1);
    addr = 32'h54; exp_rd = 32'h00000027; gap_chk = 1'b1;
    wait_acc(n + 2);
    req = 1'b0; gap_chk = 1'b0;
    drain();
    repeat (4) step();

    op(1, 2'b00, 0, 32'h55, 32'h000000FF, 0, 32'h00000027, 3, 1, 32'h0000FF27);
    check("ram_54", ram[21], 32'h0000FF27);
    op(0, 2'b00, 1, 32'h55, 32'h0, 0, 32'hFFFFFFFF, 2, 0, 32'h0);
    op(0, 2'b00, 0, 32'h55, 32'h0, 0, 32'h000000FF, 2, 0, 32'h0);
    op(1, 2'b01, 0, 32'h5E, 32'h0000ABCD, 0, 32'h000000FF, 3, 1, 32'hABCD0115);
    check("ram_5c", ram[23], 32'hABCD0115);
    op(0, 2'b01, 1, 32'h5E, 32'h0, 0, 32'hFFFFABCD, 2, 0, 32'h0);
    op(0, 2'b01, 0, 32'h5C, 32'h0, 0, 32'h00000115, 2, 0, 32'h0);
    op(0, 2'b00, 1, 32'h5F, 32'h0, 0, 32'hFFFFFFAB, 2, 0, 32'h0);
    op(0, 2'b00, 1, 32'h5C, 32'h0, 0, 32'h00000015, 2, 0, 32'h0);

    // rejected accesses keep rdata and memory intact
    op(0, 2'b10, 0, 32'h52, 32'h0, 1, 32'h00000015, 1, 0, 32'h0);
    op(1, 2'b01, 0, 32'h51, 32'h00001234, 1, 32'h00000015, 1, 0, 32'h0);
    op(0, 2'b11, 0, 32'h50, 32'h0, 1, 32'h00000015, 1, 0, 32'h0);
    op(1, 2'b10, 0, 32'h80, 32'hDEADBEEF, 1, 32'h00000015, 1, 0, 32'h0);
    check("ram_00", ram[0], 32'h0);
    check("ram_50", ram[20], 32'h000000A3);
    check("ram_51", ram[20], 32'h000000A3);
    check("ram_5c_err", ram[23], 32'hABCD0115);

    op(1, 2'b10, 0, 32'h58, 32'h12345678, 0, 32'h00000015, 2, 1, 32'h12345678);
    op(0, 2'b10, 0, 32'h58, 32'h0, 0, 32'h12345678, 2, 0, 32'h0);
    op(0, 2'b01, 0, 32'h5A, 32'h0, 0, 32'h00001234, 2, 0, 32'h0);

    // reset during the read phase of a byte store
    wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h50; wdata = 32'h11;
    exp_e = 1'b0; exp_rd = 32'h0; exp_lat = 3; exp_nwe = 1; exp_din = 32'h00000011;
    req = 1'b1;
    step();
    req = 1'b0;
    clrn = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) step();
    clrn = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_ram_50", ram[20], 32'h000000A3);
    repeat (5) step();
    check("abort_ram_50_late", ram[20], 32'h000000A3);
    op(0, 2'b10, 0, 32'h50, 32'h0, 0, 32'h000000A3, 2, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
